// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply unit: operation codes, FSM states
// and small decode helpers used by the controller.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_MADD  = 3'b010,
        OP_MSUB  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } mulop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_ACC  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Operations that run the iterative multiplier and update HI/LO at the end.
    function automatic logic is_mul_class(input mulop_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Only MULTU treats its operands as unsigned.
    function automatic logic is_signed_op(input mulop_t op);
        return (op != OP_MULTU);
    endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Iterative shift-add multiplier: latches operand magnitudes on load, then
// performs one add/shift step per cycle while step is high.
module mul_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      LAST_C = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic               neg_reg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               a_neg;
    logic               b_neg;

    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a = a_neg ? (~a + ONE_W) : a;
    assign mag_b = b_neg ? (~b + ONE_W) : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            neg_reg    <= 1'b0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_b;
            count_reg  <= '0;
            neg_reg    <= a_neg ^ b_neg;
        end else if (step) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            count_reg  <= count_reg + ONE_C;
        end
    end

    assign last    = (count_reg == LAST_C);
    assign product = neg_reg ? (~acc_reg + ONE_2W) : acc_reg;

endmodule

// File: rtl/hilo_mul_controller.sv
// HI/LO register file with a multicycle multiply/accumulate sequencer;
// MTHI/MTLO write directly from IDLE, multiply-class ops take WIDTH+2 cycles.
module hilo_mul_controller
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MulOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_t             state_reg;
    mulop_t             op_reg;
    mulop_t             op_in;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               core_load;
    logic               core_step;
    logic               core_last;
    logic [2*WIDTH-1:0] core_product;
    logic [2*WIDTH-1:0] hilo_cur;

    assign op_in     = mulop_t'(MulOp);
    assign hilo_cur  = {hi_reg, lo_reg};
    assign core_load = (state_reg == ST_IDLE) && Start && is_mul_class(op_in);
    assign core_step = (state_reg == ST_MUL);

    mul_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (core_load),
        .step     (core_step),
        .signed_op(is_signed_op(op_in)),
        .a        (A),
        .b        (B),
        .last     (core_last),
        .product  (core_product)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_MULT;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        if (is_mul_class(op_in)) begin
                            op_reg    <= op_in;
                            state_reg <= ST_MUL;
                            busy_reg  <= 1'b1;
                        end else if (op_in == OP_MTHI) begin
                            hi_reg <= A;
                        end else if (op_in == OP_MTLO) begin
                            lo_reg <= A;
                        end
                    end
                end
                ST_MUL: begin
                    if (core_last) begin
                        state_reg <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    // Accumulation wraps modulo 2^(2*WIDTH); no overflow indication.
                    case (op_reg)
                        OP_MADD: {hi_reg, lo_reg} <= hilo_cur + core_product;
                        OP_MSUB: {hi_reg, lo_reg} <= hilo_cur - core_product;
                        default: {hi_reg, lo_reg} <= core_product;
                    endcase
                    state_reg <= ST_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_hilo_mul_controller.sv
`timescale 1ns/1ps
module tb_hilo_mul_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MulOp = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;

    int done_cyc;
    int done_cnt;
    int busy_cnt;
    int first_busy;

    always #5 Clk = ~Clk;

    hilo_mul_controller #(.WIDTH(32)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .MulOp(MulOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .HI   (HI),
        .LO   (LO)
    );

    task automatic chk(input string tag, input longint obs, input longint exp, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int rst_cyc,
                          output int d_cyc, output int d_cnt, output int b_cnt, output int b_first);
        d_cyc = -1; d_cnt = 0; b_cnt = 0; b_first = -1;
        @(negedge Clk);
        Start = 1'b1; MulOp = op; A = a; B = b;
        @(posedge Clk);
        #1;
        Start = 1'b0; MulOp = 3'b111; A = ~a; B = a ^ b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (Done) begin
                d_cnt++;
                if (d_cyc < 0) d_cyc = c;
            end
            if (Busy) begin
                b_cnt++;
                if (b_first < 0) b_first = c;
            end
            if (c == inj_cyc) begin
                Start = 1'b1; MulOp = 3'b101; A = 32'h0000_1234;
            end else begin
                Start = 1'b0; MulOp = 3'b111;
            end
            if (c == rst_cyc) Reset = 1'b0;
            if (c == rst_cyc + 2) Reset = 1'b1;
        end
        $display("op=%03b A=%08h B=%08h done_cyc=%0d done_cnt=%0d busy_cnt=%0d HI=%08h LO=%08h",
                 op, a, b, d_cyc, d_cnt, b_cnt, HI, LO);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        @(negedge Clk);
        Start = 1'b1; MulOp = op; A = a;
        @(posedge Clk);
        #1;
        Start = 1'b0; MulOp = 3'b111; A = 32'hDEAD_BEEF;
        @(negedge Clk);
        $display("op=%03b A=%08h HI=%08h LO=%08h Busy=%0b Done=%0b", op, a, HI, LO, Busy, Done);
    endtask

    initial begin
        @(negedge Clk);
        chk("rst_hi", HI, 32'h0, HI === 32'h0);
        chk("rst_lo", LO, 32'h0, LO === 32'h0);
        chk("rst_busy", Busy, 1'b0, Busy === 1'b0);
        chk("rst_done", Done, 1'b0, Done === 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("multu_done_cyc", done_cyc, 34, done_cyc == 34);
        chk("multu_done_cnt", done_cnt, 1, done_cnt == 1);
        chk("multu_hi", HI, 32'hFFFF_FFFE, HI === 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001, LO === 32'h0000_0001);

        run_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("mult_busy_first", first_busy, 1, first_busy == 1);
        chk("mult_busy_cnt", busy_cnt, 33, busy_cnt == 33);
        chk("mult_done_cyc", done_cyc, 34, done_cyc == 34);
        chk("mult_hi", HI, 32'hFFFF_FFFF, HI === 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA, LO === 32'hFFFF_FFFA);

        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("mult_min_hi", HI, 32'h4000_0000, HI === 32'h4000_0000);
        chk("mult_min_lo", LO, 32'h0000_0000, LO === 32'h0000_0000);

        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("mult_m1_hi", HI, 32'h0000_0000, HI === 32'h0000_0000);
        chk("mult_m1_lo", LO, 32'h0000_0001, LO === 32'h0000_0001);

        move_to(3'b100, 32'h0000_0005);
        chk("mthi_hi", HI, 32'h0000_0005, HI === 32'h0000_0005);
        chk("mthi_lo_kept", LO, 32'h0000_0001, LO === 32'h0000_0001);
        chk("mthi_busy", Busy, 1'b0, Busy === 1'b0);
        chk("mthi_done", Done, 1'b0, Done === 1'b0);
        move_to(3'b101, 32'h0000_0007);
        chk("mtlo_lo", LO, 32'h0000_0007, LO === 32'h0000_0007);
        chk("mtlo_hi_kept", HI, 32'h0000_0005, HI === 32'h0000_0005);

        run_op(3'b010, 32'h0000_0002, 32'h0000_0003, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("madd_hi", HI, 32'h0000_0005, HI === 32'h0000_0005);
        chk("madd_lo", LO, 32'h0000_000D, LO === 32'h0000_000D);
        chk("madd_done_cnt", done_cnt, 1, done_cnt == 1);

        run_op(3'b011, 32'h0000_0002, 32'h0000_0007, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("msub_hi", HI, 32'h0000_0004, HI === 32'h0000_0004);
        chk("msub_lo", LO, 32'hFFFF_FFFF, LO === 32'hFFFF_FFFF);

        run_op(3'b000, 32'h0000_0005, 32'hFFFF_FFFD, 10, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("ign_hi", HI, 32'hFFFF_FFFF, HI === 32'hFFFF_FFFF);
        chk("ign_lo", LO, 32'hFFFF_FFF1, LO === 32'hFFFF_FFF1);
        chk("ign_done_cnt", done_cnt, 1, done_cnt == 1);
        chk("ign_done_cyc", done_cyc, 34, done_cyc == 34);

        run_op(3'b000, 32'h0000_0007, 32'h0000_0009, -1, 15, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("abort_done_cnt", done_cnt, 0, done_cnt == 0);
        chk("abort_hi", HI, 32'h0, HI === 32'h0);
        chk("abort_lo", LO, 32'h0, LO === 32'h0);
        chk("abort_busy", Busy, 1'b0, Busy === 1'b0);
        chk("abort_busy_cnt", busy_cnt, 15, busy_cnt == 15);

        run_op(3'b001, 32'h0000_0003, 32'h0000_0004, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("post_rst_lo", LO, 32'h0000_000C, LO === 32'h0000_000C);
        chk("post_rst_hi", HI, 32'h0000_0000, HI === 32'h0000_0000);
        chk("post_rst_done_cyc", done_cyc, 34, done_cyc == 34);

        run_op(3'b110, 32'h0000_ABCD, 32'h0000_1111, -1, -1, done_cyc, done_cnt, busy_cnt, first_busy);
        chk("rsv_busy_cnt", busy_cnt, 0, busy_cnt == 0);
        chk("rsv_done_cnt", done_cnt, 0, done_cnt == 0);
        chk("rsv_hi", HI, 32'h0000_0000, HI === 32'h0000_0000);
        chk("rsv_lo", LO, 32'h0000_000C, LO === 32'h0000_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
